au_op_sequencer: RTL and testbench
==================================

// Module: au_op_sequencer
// PURPOSE
//  Cycle-accurate command sequencer for the 16-bit arithmetic unit datapath (regs A/B, adder, bit-select mux).
//  Accepts one command at a time (load/read/ADD/SUB/MUL) via valid/ready and emits per-cycle datapath strobes.
//  MUL is shift-and-add: 8-bit operand x Reg_A, accumulated in Reg_B. Latches P/N flags and a sticky mode error.
// PARAMETERS
//  MUL_BITS  8  multiplier operand width = number of MUL iterations
//  BSEL_W    3  width of bit_sel; must satisfy 2**BSEL_W >= MUL_BITS
// PORTS
//  CLK        in   1        single clock, all state updates on rising edge
//  RST        in   1        synchronous reset, active-high
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        sequencer can accept; high only in IDLE
//  cmd_op     in   2        00 LDR, 01 ADD, 10 SUB, 11 MUL
//  cmd_reg    in   2        {REG1,REG0}: 00 A_lo, 01 A_hi, 10 B_lo, 11 B_hi
//  cmd_rw     in   1        LDR: 1 write, 0 read; ADD/SUB: 1 use Reg_A, 0 use ui_in
//  cmd_signed in   1        two's-complement mode (C)
//  mul_bit    in   1        datapath operand bit selected by bit_sel
//  dp_cout    in   1        adder carry out
//  dp_sum15   in   1        adder SUM[15]
//  ld_a_lo/ld_a_hi/ld_b_lo/ld_b_hi out 1  one-cycle register write strobes
//  clr_b      out  1        clear Reg_B
//  acc_b      out  1        Reg_B <= SUM
//  sh_a       out  1        Reg_A <= Reg_A << 1
//  neg        out  1        adder B-input inverted, Cin=1
//  src_a      out  1        adder B-input from Reg_A (else ui_in, sign-extended when signed)
//  bit_sel    out  BSEL_W   current MUL iteration index
//  rd_sel     out  2        output mux select, updated on LDR read
//  busy       out  1        high in any state except IDLE
//  done       out  1        one-cycle pulse in DONE
//  flag_p     out  1        overflow/carry = dp_cout ^ (signed & dp_sum15)
//  flag_n     out  1        negative = dp_sum15 & (SUB | signed&(ADD|MUL))
//  err        out  1        sticky: cmd_signed changed between two consecutively accepted commands
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready=1; rd_sel=0, bit_sel=0, flags/err/saved mode cleared.
//  Reset mid-operation: abort at next edge; no further strobes; partial Reg_A/Reg_B contents left as-is.
//  Accept on cmd_valid & cmd_ready; operands latched; ready low from next cycle until return to IDLE.
//  FSM IDLE->(LOAD|EXEC|CLR)->...->DONE->IDLE; DONE lasts exactly 1 cycle, then ready=1.
//  LDR write: LOAD 1 cycle, exactly one ld_* strobe per cmd_reg; then DONE. Latency accept->done = 2.
//  LDR read: rd_sel<=cmd_reg at accept; LOAD with no strobe; DONE. Flags unchanged.
//  ADD/SUB: EXEC 1 cycle: acc_b=1, neg=(SUB), src_a=cmd_rw; flags captured at EXEC edge. Latency 2.
//  MUL: CLR (clr_b=1) then for i=0..MUL_BITS-1: ACC (bit_sel=i, acc_b=mul_bit,
//   neg=signed & i==MUL_BITS-1 & mul_bit, src_a=1) then SHIFT (sh_a=1, bit_sel++).
//   Latency = 2*MUL_BITS+2 (18 default). Flags captured at last ACC only; bit_sel returns to 0 in DONE.
//  At most one of ld_*/clr_b/acc_b/sh_a high in any cycle; none high in IDLE/DONE.
//  err: compares cmd_signed to saved mode at each accept after the first; set on mismatch, cleared only by RST.
//  cmd_valid while busy: ignored, not queued; requester must hold until ready.
// CONFIGURATION
//  AU_SEQ_EARLY_TERM_EN defined: MUL ends after the SHIFT of iteration i when signed=0 and the
//   operand bits above i are all zero (input mul_rem_zero, 1 bit, added under the macro); done
//   then follows that SHIFT. Not defined: always full MUL_BITS iterations; port absent.
// TESTING
//  LDR write A_lo 0x34, A_hi 0x12 -> ld_a_lo then ld_a_hi strobes, 1 cycle each; done 2 cycles after each accept.
//  ADD ui_in=0x05 to B=0xFFFE unsigned -> acc_b 1 cycle, neg=0, flag_p=1, flag_n=0, latency 2.
//  MUL unsigned A=0x0003 x 0xA5 -> acc_b only at i=0,2,5,7, 8 sh_a pulses, done at cycle 18.
//  MUL signed operand 0x80 -> neg=1 only at i=7 ACC; flag_n latched from dp_sum15 there.
//  Accept ADD signed=0 then SUB signed=1 -> err=1 and stays 1 until RST; RST at MUL i=3 -> IDLE, no strobes.
//  With AU_SEQ_EARLY_TERM_EN, unsigned operand 0x01, mul_rem_zero=1 from i=0 -> done 4 cycles after accept.

Source files
------------

// File: rtl/au_op_sequencer.sv
// Command sequencer for the 16-bit arithmetic unit: LDR/ADD/SUB/MUL into per-cycle datapath strobes.
// Optional build macro AU_SEQ_EARLY_TERM_EN adds mul_rem_zero and ends unsigned MUL once no operand bits remain.
module au_op_sequencer #(
    parameter int unsigned MUL_BITS = 8,
    parameter int unsigned BSEL_W   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_reg,
    input  logic              cmd_rw,
    input  logic              cmd_signed,
    input  logic              mul_bit,
    input  logic              dp_cout,
    input  logic              dp_sum15,
`ifdef AU_SEQ_EARLY_TERM_EN
    input  logic              mul_rem_zero,
`endif
    output logic              ld_a_lo,
    output logic              ld_a_hi,
    output logic              ld_b_lo,
    output logic              ld_b_hi,
    output logic              clr_b,
    output logic              acc_b,
    output logic              sh_a,
    output logic              neg,
    output logic              src_a,
    output logic [BSEL_W-1:0] bit_sel,
    output logic [1:0]        rd_sel,
    output logic              busy,
    output logic              done,
    output logic              flag_p,
    output logic              flag_n,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_EXEC, S_CLR, S_ACC, S_SHIFT, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_LDR = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_MUL = 2'b11
    } op_t;

    localparam logic [BSEL_W-1:0] LAST = BSEL_W'(MUL_BITS - 1);

    state_t             r_state, w_next;
    op_t                r_op;
    logic [1:0]         r_reg;
    logic               r_rw;
    logic               r_signed;
    logic               r_mode;
    logic               r_mode_valid;
    logic [BSEL_W-1:0]  r_bit_sel;
    logic [1:0]         r_rd_sel;
    logic               r_flag_p;
    logic               r_flag_n;
    logic               r_err;
    logic               w_accept;
    logic               w_mul_end;

    assign w_accept = cmd_valid && (r_state == S_IDLE);

    // The last iteration both captures flags (in ACC) and leaves for DONE (after SHIFT).
`ifdef AU_SEQ_EARLY_TERM_EN
    assign w_mul_end = (r_bit_sel == LAST) || (!r_signed && mul_rem_zero);
`else
    assign w_mul_end = (r_bit_sel == LAST);
`endif

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        ld_a_lo   = 1'b0;
        ld_a_hi   = 1'b0;
        ld_b_lo   = 1'b0;
        ld_b_hi   = 1'b0;
        clr_b     = 1'b0;
        acc_b     = 1'b0;
        sh_a      = 1'b0;
        neg       = 1'b0;
        src_a     = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept) begin
                    case (op_t'(cmd_op))
                        OP_LDR:  w_next = S_LOAD;
                        OP_MUL:  w_next = S_CLR;
                        default: w_next = S_EXEC;
                    endcase
                end
            end
            S_LOAD: begin
                if (r_rw) begin
                    ld_a_lo = (r_reg == 2'b00);
                    ld_a_hi = (r_reg == 2'b01);
                    ld_b_lo = (r_reg == 2'b10);
                    ld_b_hi = (r_reg == 2'b11);
                end
                w_next = S_DONE;
            end
            S_EXEC: begin
                acc_b  = 1'b1;
                neg    = (r_op == OP_SUB);
                src_a  = r_rw;
                w_next = S_DONE;
            end
            S_CLR: begin
                clr_b  = 1'b1;
                w_next = S_ACC;
            end
            S_ACC: begin
                acc_b  = mul_bit;
                neg    = r_signed && (r_bit_sel == LAST) && mul_bit;
                src_a  = 1'b1;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                sh_a   = 1'b1;
                w_next = w_mul_end ? S_DONE : S_ACC;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_op         <= OP_LDR;
            r_reg        <= '0;
            r_rw         <= 1'b0;
            r_signed     <= 1'b0;
            r_mode       <= 1'b0;
            r_mode_valid <= 1'b0;
            r_bit_sel    <= '0;
            r_rd_sel     <= '0;
            r_flag_p     <= 1'b0;
            r_flag_n     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op         <= op_t'(cmd_op);
                r_reg        <= cmd_reg;
                r_rw         <= cmd_rw;
                r_signed     <= cmd_signed;
                r_bit_sel    <= '0;
                r_mode       <= cmd_signed;
                r_mode_valid <= 1'b1;
                if (r_mode_valid && (cmd_signed != r_mode))
                    r_err <= 1'b1;
                if ((op_t'(cmd_op) == OP_LDR) && !cmd_rw)
                    r_rd_sel <= cmd_reg;
            end
            if (r_state == S_EXEC) begin
                r_flag_p <= dp_cout ^ (r_signed & dp_sum15);
                r_flag_n <= dp_sum15 & ((r_op == OP_SUB) | (r_signed & (r_op == OP_ADD)));
            end
            if ((r_state == S_ACC) && w_mul_end) begin
                r_flag_p <= dp_cout ^ (r_signed & dp_sum15);
                r_flag_n <= dp_sum15 & r_signed;
            end
            if (r_state == S_SHIFT)
                r_bit_sel <= w_mul_end ? '0 : r_bit_sel + BSEL_W'(1);
        end
    end

    assign bit_sel = r_bit_sel;
    assign rd_sel  = r_rd_sel;
    assign flag_p  = r_flag_p;
    assign flag_n  = r_flag_n;
    assign err     = r_err;

endmodule

// File: tb/tb_au_op_sequencer.sv
// Scoreboard bench for au_op_sequencer: per-cycle expected output vectors are queued at issue and compared each cycle.
module tb_au_op_sequencer;

    localparam int unsigned MUL_BITS = 8;
    localparam int unsigned BSEL_W   = 3;
    localparam logic [1:0] OP_LDR = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_MUL = 2'b11;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST, cmd_valid, cmd_ready, cmd_rw, cmd_signed, mul_bit, dp_cout, dp_sum15;
    logic [1:0] cmd_op, cmd_reg, rd_sel;
    logic ld_a_lo, ld_a_hi, ld_b_lo, ld_b_hi, clr_b, acc_b, sh_a, neg, src_a;
    logic busy, done, flag_p, flag_n, err;
    logic [BSEL_W-1:0] bit_sel;
    logic [7:0] tb_operand;

    // Datapath stand-in: operand bit picked by the sequencer's bit_sel.
    assign mul_bit = tb_operand[bit_sel];
`ifdef AU_SEQ_EARLY_TERM_EN
    logic mul_rem_zero;
    assign mul_rem_zero = ((tb_operand >> bit_sel) >> 1) == 8'd0;
`endif

    au_op_sequencer #(.MUL_BITS(MUL_BITS), .BSEL_W(BSEL_W)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_rw(cmd_rw), .cmd_signed(cmd_signed),
        .mul_bit(mul_bit), .dp_cout(dp_cout), .dp_sum15(dp_sum15),
`ifdef AU_SEQ_EARLY_TERM_EN
        .mul_rem_zero(mul_rem_zero),
`endif
        .ld_a_lo(ld_a_lo), .ld_a_hi(ld_a_hi), .ld_b_lo(ld_b_lo), .ld_b_hi(ld_b_hi),
        .clr_b(clr_b), .acc_b(acc_b), .sh_a(sh_a), .neg(neg), .src_a(src_a),
        .bit_sel(bit_sel), .rd_sel(rd_sel), .busy(busy), .done(done),
        .flag_p(flag_p), .flag_n(flag_n), .err(err)
    );

    typedef struct packed {
        logic [3:0] ld;
        logic clr, acc, sh, ng, srca, bsy, dn, rdy, fp, fn, er;
        logic [2:0] bsel;
        logic [1:0] rsel;
    } vec_t;

    vec_t obs;
    assign obs = {ld_a_lo, ld_a_hi, ld_b_lo, ld_b_hi, clr_b, acc_b, sh_a, neg, src_a,
                  busy, done, cmd_ready, flag_p, flag_n, err, bit_sel, rd_sel};

    int n_checks = 0;
    int n_errors = 0;
    vec_t  exp_q[$];
    string tag_q[$];

    logic m_fp, m_fn, m_err, m_mode, m_first;
    logic [1:0] m_rsel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        vec_t  ev;
        string tg;
        if (exp_q.size() != 0) begin
            ev = exp_q.pop_front();
            tg = tag_q.pop_front();
            check_eq(tg, 32'(obs), 32'(ev));
        end
    end

    function automatic vec_t base(input logic bsy_, input logic rdy_);
        vec_t v = '0;
        v.bsy = bsy_; v.rdy = rdy_;
        v.fp = m_fp; v.fn = m_fn; v.er = m_err; v.rsel = m_rsel;
        return v;
    endfunction

    task automatic push_lim(input string tag, input vec_t v, inout int n, input int cut);
        if (n < cut) begin
            exp_q.push_back(v);
            tag_q.push_back(tag);
        end
        n++;
    endtask

    task automatic model_reset();
        m_fp = 0; m_fn = 0; m_err = 0; m_mode = 0; m_first = 1; m_rsel = 2'b00;
    endtask

    function automatic logic [1:0] calc(input logic [15:0] b, input logic [15:0] x, input logic sub);
        logic [16:0] r;
        r = {1'b0, b} + {1'b0, sub ? ~x : x} + 17'(sub);
        return {r[16], r[15]};
    endfunction

    // Expected per-cycle vectors from the accept cycle through DONE (first 'cut' of them).
    task automatic sched(input logic [1:0] op, input logic [1:0] rg, input logic rw,
                         input logic sg, input logic [7:0] opnd, input int cut);
        vec_t v;
        int n = 0;
        logic stop;
        push_lim("accept", base(1'b0, 1'b1), n, cut);
        if (!m_first && sg != m_mode) m_err = 1;
        m_mode = sg; m_first = 0;
        if (op == OP_LDR && !rw) m_rsel = rg;
        case (op)
            OP_LDR: begin
                v = base(1, 0);
                if (rw) v.ld = 4'b1000 >> rg;
                push_lim("ldr_load", v, n, cut);
            end
            OP_ADD, OP_SUB: begin
                v = base(1, 0); v.acc = 1; v.ng = (op == OP_SUB); v.srca = rw;
                push_lim("addsub_exec", v, n, cut);
                m_fp = dp_cout ^ (sg & dp_sum15);
                m_fn = dp_sum15 & ((op == OP_SUB) | (sg & (op == OP_ADD)));
            end
            default: begin
                v = base(1, 0); v.clr = 1;
                push_lim("mul_clr", v, n, cut);
                for (int i = 0; i < 8; i++) begin
                    v = base(1, 0); v.bsel = 3'(i); v.acc = opnd[i]; v.srca = 1;
                    v.ng = sg && (i == 7) && opnd[i];
                    push_lim($sformatf("mul_acc%0d", i), v, n, cut);
                    stop = (i == 7);
`ifdef AU_SEQ_EARLY_TERM_EN
                    stop = stop || (!sg && ((opnd >> i) >> 1) == 8'd0);
`endif
                    if (stop) begin
                        m_fp = dp_cout ^ (sg & dp_sum15);
                        m_fn = dp_sum15 & sg;
                    end
                    v = base(1, 0); v.bsel = 3'(i); v.sh = 1;
                    push_lim($sformatf("mul_shift%0d", i), v, n, cut);
                    if (stop) break;
                end
            end
        endcase
        v = base(1, 0); v.dn = 1;
        push_lim("done", v, n, cut);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0) begin
            if (n == 300) begin
                check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
                tag_q.delete();
                break;
            end
            @(negedge CLK); #1;
            n++;
        end
    endtask

    // cmd_valid stays high one extra (busy) cycle to show it is ignored while busy.
    task automatic issue(input logic [1:0] op, input logic [1:0] rg, input logic rw, input logic sg,
                         input logic [7:0] opnd, input logic c, input logic s, input int cut = 1000);
        wait_drain();
        @(posedge CLK); #1;
        cmd_op = op; cmd_reg = rg; cmd_rw = rw; cmd_signed = sg;
        tb_operand = opnd; dp_cout = c; dp_sum15 = s; cmd_valid = 1;
        sched(op, rg, rw, sg, opnd, cut);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        cmd_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] cs;
        RST = 1; cmd_valid = 0; cmd_op = 0; cmd_reg = 0; cmd_rw = 0; cmd_signed = 0;
        dp_cout = 0; dp_sum15 = 0; tb_operand = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        exp_q.push_back(base(0, 1)); tag_q.push_back("reset");
        @(posedge CLK); #1;
        RST = 0;

        issue(OP_LDR, 2'b00, 1, 0, 8'h34, 0, 0);
        issue(OP_LDR, 2'b01, 1, 0, 8'h12, 0, 0);
        issue(OP_LDR, 2'b10, 1, 0, 8'h00, 0, 0);
        issue(OP_LDR, 2'b11, 1, 0, 8'h00, 0, 0);
        issue(OP_LDR, 2'b10, 0, 0, 8'h00, 0, 0);

        cs = calc(16'hFFFE, 16'h0005, 0);
        issue(OP_ADD, 2'b00, 0, 0, 8'h05, cs[1], cs[0]);

        issue(OP_MUL, 2'b00, 1, 0, 8'hA5, 1, 1);
        issue(OP_MUL, 2'b00, 1, 0, 8'h01, 0, 0);

        cs = calc(16'h0003, 16'h1234, 1);
        issue(OP_SUB, 2'b00, 1, 1, 8'h00, cs[1], cs[0]);

        issue(OP_MUL, 2'b00, 1, 1, 8'h80, 1, 1);

        // Reset asserted during ACC of iteration 3 (ninth cycle from accept).
        issue(OP_MUL, 2'b00, 1, 1, 8'hFF, 0, 0, 9);
        repeat (6) @(posedge CLK);
        #1;
        RST = 1;
        model_reset();
        exp_q.push_back(base(0, 1)); tag_q.push_back("mid_mul_reset");
        exp_q.push_back(base(0, 1)); tag_q.push_back("mid_mul_reset");
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 0;

        issue(OP_LDR, 2'b01, 0, 1, 8'h00, 0, 0);
        cs = calc(16'h7FFF, 16'h0001, 0);
        issue(OP_ADD, 2'b00, 1, 1, 8'h00, cs[1], cs[0]);
        issue(OP_ADD, 2'b00, 0, 0, 8'h00, 0, 0);

        wait_drain();
        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
